// File: rtl/conv2d_mc_if.sv
// Stream bundle for the convolution engine: filter in, activation in, result out.
// The master side is the job driver; the slave side is the engine.
interface conv2d_mc_if #(
  parameter int DW = 8,
  parameter int FW = 9,
  parameter int OW = 20
);
  logic                 f_valid;
  logic                 f_ready;
  logic signed [FW-1:0] f_data;
  logic                 a_valid;
  logic                 a_ready;
  logic signed [DW-1:0] a_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;

  modport master (
    output f_valid, f_data, a_valid, a_data, out_ready,
    input  f_ready, a_ready, out_valid, out_data
  );

  modport slave (
    input  f_valid, f_data, a_valid, a_data, out_ready,
    output f_ready, a_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv2d_mc_engine.sv
// Self-sequenced multi-channel 2-D convolution: load filters, load activations,
// then one MAC per cycle per output pixel, with padding, stride, ReLU and saturation.
module conv2d_mc_engine #(
  parameter int DW  = 8,
  parameter int FW  = 9,
  parameter int OW  = 20,
  parameter int AS  = 6,
  parameter int FS  = 3,
  parameter int STR = 1,
  parameter int ZP  = 0,
  parameter int CH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_relu,
  conv2d_mc_if.slave       bus,
  output logic             busy,
  output logic             done
);

  localparam int PS   = AS + 2*ZP;
  localparam int OS   = (PS - FS) / STR + 1;
  localparam int NF   = CH*FS*FS;
  localparam int NS   = CH*PS*PS;
  localparam int ACCW = DW + FW + $clog2(NF);
  localparam int CW   = $clog2(CH + PS);
  localparam int FAW  = (NF > 1) ? $clog2(NF) : 1;
  localparam int SAW  = (NS > 1) ? $clog2(NS) : 1;
  localparam logic signed [63:0] OMAX = (64'sd1 <<< (OW-1)) - 64'sd1;
  localparam logic signed [63:0] OMIN = -(64'sd1 <<< (OW-1));

  if (FS > AS + 2*ZP || STR < 1) begin : g_bad_cfg
    $error("conv2d_mc_engine: filter larger than padded map, or zero stride");
  end

  typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_A, MAC, EMIT, FIN} state_t;
  state_t state;

  logic                      relu_q;
  logic [FAW-1:0]            f_cnt;
  logic [CW-1:0]             lch, lr, lc;
  logic [CW-1:0]             mch, mfr, mfc;
  logic [CW-1:0]             orow, ocol;
  logic signed [ACCW-1:0]    acc;

  // Store includes the padding ring; it is zeroed at start and only the interior is written.
  logic signed [DW-1:0]      store [NS];
  logic signed [FW-1:0]      filt  [NF];

  logic [SAW-1:0]            rd_addr, wr_addr;
  logic [FAW-1:0]            fr_addr;
  logic signed [DW+FW-1:0]   prod;
  logic signed [ACCW-1:0]    acc_next;
  logic signed [63:0]        wide;
  logic signed [OW-1:0]      res;
  logic                      mac_last, f_fire, a_fire;

  always_comb begin
    rd_addr  = SAW'(int'(mch)*PS*PS + (int'(orow)*STR + int'(mfr))*PS
                    + int'(ocol)*STR + int'(mfc));
    wr_addr  = SAW'(int'(lch)*PS*PS + (int'(lr) + ZP)*PS + int'(lc) + ZP);
    fr_addr  = FAW'(int'(mch)*FS*FS + int'(mfr)*FS + int'(mfc));
    prod     = (DW+FW)'(store[rd_addr]) * (DW+FW)'(filt[fr_addr]);
    acc_next = acc + ACCW'(prod);
    mac_last = (mch == CW'(CH-1)) && (mfr == CW'(FS-1)) && (mfc == CW'(FS-1));
    f_fire   = bus.f_valid && bus.f_ready;
    a_fire   = bus.a_valid && bus.a_ready;

    // ReLU first, then clamp to the signed output range.
    wide = 64'(acc_next);
    if (relu_q && wide < 64'sd0) wide = 64'sd0;
    if (wide > OMAX)      res = OMAX[OW-1:0];
    else if (wide < OMIN) res = OMIN[OW-1:0];
    else                  res = wide[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < NS; i++) store[i] <= '0;
    end else if (a_fire) begin
      store[wr_addr] <= bus.a_data;
    end
    if (f_fire) filt[f_cnt] <= bus.f_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      relu_q        <= 1'b0;
      f_cnt         <= '0;
      lch           <= '0;
      lr            <= '0;
      lc            <= '0;
      mch           <= '0;
      mfr           <= '0;
      mfc           <= '0;
      orow          <= '0;
      ocol          <= '0;
      acc           <= '0;
      bus.f_ready   <= 1'b0;
      bus.a_ready   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            relu_q      <= cfg_relu;
            acc         <= '0;
            f_cnt       <= '0;
            lch         <= '0;
            lr          <= '0;
            lc          <= '0;
            mch         <= '0;
            mfr         <= '0;
            mfc         <= '0;
            orow        <= '0;
            ocol        <= '0;
            bus.f_ready <= 1'b1;
            busy        <= 1'b1;
            state       <= LOAD_F;
          end
        end
        LOAD_F: begin
          if (f_fire) begin
            if (f_cnt == FAW'(NF-1)) begin
              bus.f_ready <= 1'b0;
              bus.a_ready <= 1'b1;
              state       <= LOAD_A;
            end else begin
              f_cnt <= f_cnt + FAW'(1);
            end
          end
        end
        LOAD_A: begin
          if (a_fire) begin
            if (lc == CW'(AS-1)) begin
              lc <= '0;
              if (lr == CW'(AS-1)) begin
                lr <= '0;
                if (lch == CW'(CH-1)) begin
                  lch         <= '0;
                  bus.a_ready <= 1'b0;
                  state       <= MAC;
                end else begin
                  lch <= lch + CW'(1);
                end
              end else begin
                lr <= lr + CW'(1);
              end
            end else begin
              lc <= lc + CW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc_next;
          if (mfc == CW'(FS-1)) begin
            mfc <= '0;
            if (mfr == CW'(FS-1)) begin
              mfr <= '0;
              mch <= (mch == CW'(CH-1)) ? '0 : mch + CW'(1);
            end else begin
              mfr <= mfr + CW'(1);
            end
          end else begin
            mfc <= mfc + CW'(1);
          end
          // Result registered off the final sum so out_valid rises with no extra cycle.
          if (mac_last) begin
            bus.out_data  <= res;
            bus.out_valid <= 1'b1;
            state         <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
            state         <= MAC;
            if (ocol == CW'(OS-1)) begin
              ocol <= '0;
              if (orow == CW'(OS-1)) begin
                orow  <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                orow <= orow + CW'(1);
              end
            end else begin
              ocol <= ocol + CW'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_mc_engine.sv
// Bench for conv2d_mc_engine: two parameterisations, random and directed jobs
// compared against a direct window-sum reference model.
module tb_conv2d_mc_engine;

  // Instance 0: AS=6 FS=3 STR=1 ZP=0 CH=2 OW=20. Instance 1: AS=5 FS=3 STR=2 ZP=1 CH=1 OW=12.
  localparam int P_AS [2] = '{6, 5};
  localparam int P_FS [2] = '{3, 3};
  localparam int P_ST [2] = '{1, 2};
  localparam int P_ZP [2] = '{0, 1};
  localparam int P_CH [2] = '{2, 1};
  localparam int P_OW [2] = '{20, 12};

  logic clk, rst;
  logic start0, start1, cfg_relu;
  logic busy0, busy1, done0, done1;
  logic f_valid, a_valid, out_ready;
  logic signed [8:0] f_data;
  logic signed [7:0] a_data;
  int   sel;

  conv2d_mc_if #(.DW(8), .FW(9), .OW(20)) if0 ();
  conv2d_mc_if #(.DW(8), .FW(9), .OW(12)) if1 ();

  assign if0.f_valid = f_valid;  assign if1.f_valid = f_valid;
  assign if0.f_data  = f_data;   assign if1.f_data  = f_data;
  assign if0.a_valid = a_valid;  assign if1.a_valid = a_valid;
  assign if0.a_data  = a_data;   assign if1.a_data  = a_data;
  assign if0.out_ready = out_ready & (sel == 0);
  assign if1.out_ready = out_ready & (sel == 1);

  conv2d_mc_engine #(.DW(8), .FW(9), .OW(20), .AS(6), .FS(3), .STR(1), .ZP(0), .CH(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cfg_relu(cfg_relu), .bus(if0),
    .busy(busy0), .done(done0));

  conv2d_mc_engine #(.DW(8), .FW(9), .OW(12), .AS(5), .FS(3), .STR(2), .ZP(1), .CH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_relu(cfg_relu), .bus(if1),
    .busy(busy1), .done(done1));

  logic f_ready_m, a_ready_m, out_valid_m, busy_m, done_m;
  int   od;
  assign f_ready_m   = (sel == 1) ? if1.f_ready   : if0.f_ready;
  assign a_ready_m   = (sel == 1) ? if1.a_ready   : if0.a_ready;
  assign out_valid_m = (sel == 1) ? if1.out_valid : if0.out_valid;
  assign busy_m      = (sel == 1) ? busy1 : busy0;
  assign done_m      = (sel == 1) ? done1 : done0;
  assign od          = (sel == 1) ? int'(if1.out_data) : int'(if0.out_data);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int a_mem [256];
  int f_mem [64];
  int exp_q [$];

  task automatic chk(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // mode: 0 random, 1 ch0 a=1/f=1 and ch1 a=2/f=-1, 2 a=127 f=255, 3 a=-128 f=255, 4 all ones, 5 ramp a, f=1
  task automatic fill(input int s, input int mode);
    int as_, fs_, ch_;
    as_ = P_AS[s]; fs_ = P_FS[s]; ch_ = P_CH[s];
    for (int c = 0; c < ch_; c++) begin
      for (int i = 0; i < as_*as_; i++) begin
        case (mode)
          0: a_mem[c*as_*as_+i] = int'($urandom_range(255)) - 128;
          1: a_mem[c*as_*as_+i] = (c == 0) ? 1 : 2;
          2: a_mem[c*as_*as_+i] = 127;
          3: a_mem[c*as_*as_+i] = -128;
          5: a_mem[c*as_*as_+i] = i;
          default: a_mem[c*as_*as_+i] = 1;
        endcase
      end
      for (int i = 0; i < fs_*fs_; i++) begin
        case (mode)
          0: f_mem[c*fs_*fs_+i] = int'($urandom_range(511)) - 256;
          1: f_mem[c*fs_*fs_+i] = (c == 0) ? 1 : -1;
          2, 3: f_mem[c*fs_*fs_+i] = 255;
          default: f_mem[c*fs_*fs_+i] = 1;
        endcase
      end
    end
  endtask

  // Reference: each output is a window sum over the zero-extended map, then ReLU, then clamp.
  task automatic build_expected(input int s, input bit relu);
    int as_, fs_, st_, zp_, ch_, os_, omax, omin, sum, r, c;
    as_ = P_AS[s]; fs_ = P_FS[s]; st_ = P_ST[s]; zp_ = P_ZP[s]; ch_ = P_CH[s];
    os_  = (as_ + 2*zp_ - fs_) / st_ + 1;
    omax = (1 << (P_OW[s]-1)) - 1;
    omin = -(1 << (P_OW[s]-1));
    exp_q.delete();
    for (int orow = 0; orow < os_; orow++) begin
      for (int ocol = 0; ocol < os_; ocol++) begin
        sum = 0;
        for (int ch = 0; ch < ch_; ch++)
          for (int fr = 0; fr < fs_; fr++)
            for (int fc = 0; fc < fs_; fc++) begin
              r = orow*st_ + fr - zp_;
              c = ocol*st_ + fc - zp_;
              if (r >= 0 && r < as_ && c >= 0 && c < as_)
                sum += a_mem[ch*as_*as_ + r*as_ + c] * f_mem[ch*fs_*fs_ + fr*fs_ + fc];
            end
        if (relu && sum < 0) sum = 0;
        if (sum > omax) sum = omax;
        if (sum < omin) sum = omin;
        exp_q.push_back(sum);
      end
    end
  endtask

  task automatic feed(input bit is_a, input int n);
    int  i, guard;
    bit  v, hit;
    i = 0; guard = 0;
    while (i < n && guard < 5000) begin
      v = ($urandom_range(3) != 0);
      if (is_a) begin a_valid = v; a_data = 8'(a_mem[i]); end
      else      begin f_valid = v; f_data = 9'(f_mem[i]); end
      @(negedge clk);
      hit = v && (is_a ? a_ready_m : f_ready_m);
      @(posedge clk); #1;
      if (hit) i++;
      guard++;
    end
    f_valid = 1'b0;
    a_valid = 1'b0;
    chk(is_a ? "a_beats" : "f_beats", i, n);
  endtask

  task automatic start_and_load(input int s, input bit relu);
    sel = s;
    cfg_relu = relu;
    start0 = (s == 0);
    start1 = (s == 1);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; cfg_relu = 1'b0;
    chk("busy_after_start", busy_m, 1);
    chk("f_ready_after_start", f_ready_m, 1);
    feed(1'b0, P_CH[s]*P_FS[s]*P_FS[s]);
    feed(1'b1, P_CH[s]*P_AS[s]*P_AS[s]);
  endtask

  task automatic run_job(input int s, input int mode, input bit relu, input int hold);
    int k, guard, held, prev_d, n;
    bit pend;
    fill(s, mode);
    build_expected(s, relu);
    n = exp_q.size();
    start_and_load(s, relu);
    k = 0; guard = 0; held = 0; pend = 1'b0; prev_d = 0;
    while (k < n && guard < 20000) begin
      if (hold > 0 && k == 0 && held < hold) out_ready = 1'b0;
      else out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (pend) begin
        chk("stall_valid", out_valid_m, 1);
        chk("stall_data", od, prev_d);
      end
      pend = 1'b0;
      if (out_valid_m && out_ready) begin
        chk($sformatf("pix_s%0d_m%0d_k%0d", s, mode, k), od, exp_q[k]);
        k++;
      end else if (out_valid_m) begin
        pend = 1'b1;
        prev_d = od;
        if (k == 0) held++;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    chk("pix_count", k, n);
    @(negedge clk);
    chk("done_pulse", done_m, 1);
    chk("busy_at_done", busy_m, 0);
    chk("valid_at_done", out_valid_m, 0);
    @(negedge clk);
    chk("done_clear", done_m, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_m, 0);
    chk({tag, "_done"}, done_m, 0);
    chk({tag, "_f_ready"}, f_ready_m, 0);
    chk({tag, "_a_ready"}, a_ready_m, 0);
    chk({tag, "_out_valid"}, out_valid_m, 0);
    chk({tag, "_out_data"}, od, 0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; cfg_relu = 1'b0;
    f_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b0;
    f_data = '0; a_data = '0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    sel = 1;
    #1 check_reset_outputs("rst1");
    sel = 0;
    @(posedge clk); #1 rst = 1'b0;

    run_job(0, 1, 1'b0, 10);   // -9 everywhere, first pixel back-pressured
    run_job(0, 1, 1'b1, 0);    // same with ReLU: 0
    run_job(0, 2, 1'b0, 0);    // 582930 clamps to 524287
    run_job(0, 3, 1'b0, 0);    // -587520 clamps to -524288
    run_job(0, 0, 1'b0, 3);
    run_job(0, 0, 1'b1, 0);
    run_job(1, 4, 1'b0, 0);    // padded ones: corners 4, edges 6, centre 9
    run_job(1, 5, 1'b0, 0);
    run_job(1, 0, 1'b0, 0);
    run_job(1, 0, 1'b1, 0);

    // Abort mid-MAC with async reset, then a clean job must still be exact.
    fill(0, 0);
    start_and_load(0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_abort_busy", busy_m, 1);
    rst = 1'b1;
    #1 check_reset_outputs("abort");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_job(0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
